rtc_3wire_responder: RTL
========================

Name: rtc_3wire_responder

Overview:
- Synthesizable DS1302-style 3-wire slave that answers the team's 3-wire RTC master on the same rtc_rst/rtc_sclk/rtc_sio bus.
- Holds an 8 x 8-bit register file. It decodes the command byte, then either accepts one write byte or returns one read byte.
- Used as an on-board chip model for loopback testing and as an emulation target when no physical RTC is fitted.
- All bus inputs are oversampled by CLK; the bus timing is far slower than CLK (0.5 us half-periods against a 20 ns CLK).

Parameters:
- SYNC_STAGES, 2, synchronizer depth on rtc_rst, rtc_sclk and rtc_sio (minimum 2).
- REG_INIT, 8'h00, reset value of every register-file entry.

Ports:
- CLK  input  1  system clock (50 MHz).
- RSTn  input  1  reset, asynchronous, active-low.
- rtc_rst  input  1  bus chip-enable from master; active high.
- rtc_sclk  input  1  bus serial clock from master.
- rtc_sio  inout  1  bus data; driven only while sio_oe=1, otherwise 1'bz.
- host_addr  input  3  local read address into the register file.
- host_rdata  output  8  combinational read of reg[host_addr].
- wr_valid  output  1  one-CLK pulse when a bus write commits.
- wr_addr  output  3  address of the last bus write; held between writes.
- wr_data  output  8  data of the last bus write; held between writes.
- busy  output  1  high while the state machine is not in IDLE.

Behaviour:
- Input conditioning:
  - rtc_rst, rtc_sclk and rtc_sio pass through SYNC_STAGES flops.
  - rise/fall of sclk are detected on the synchronized signal, giving one-CLK edge strobes.
- Reset values: every register = REG_INIT; sio_oe=0; wr_valid=0; wr_addr=0; wr_data=0; busy=0; state=IDLE; bit counter=0.
- States: IDLE, CMD, WDATA, RDATA, HOLD.
- IDLE:
  - On synchronized rst rising → CMD, bit counter=0.
  - SCLK edges are ignored while rst is low.
- CMD:
  - Each sclk rise shifts in sio, LSB first, into cmd[bit].
  - On the 8th rise, decode cmd:
    - cmd[7]=0 → HOLD (invalid command, no response).
    - cmd[0]=1 (read) → RDATA; load shift register with reg[cmd[3:1]].
    - cmd[0]=0 (write) → WDATA.
  - cmd[6:4] are ignored.
- WDATA:
  - 8 sclk rises capture data LSB first.
  - On the 8th rise: reg[cmd[3:1]] <= data, wr_addr/wr_data updated, wr_valid=1 for exactly one CLK → HOLD.
- RDATA:
  - Each sclk fall sets sio_oe=1 and drives the next bit, LSB first (bit0 on the 1st fall after the command byte).
  - The bit is held until the next fall.
  - After bit7 is driven, the 9th fall releases sio_oe=0 → HOLD.
- HOLD: ignore all edges until rst falls.
- rst falling in any state (including mid-byte):
  - → IDLE and sio_oe=0 in the same CLK as the synchronized rst=0.
  - A partial write byte is discarded; no register changes and no wr_valid.
- Latency:
  - Bus edge to internal action = SYNC_STAGES+1 CLK.
  - Read bit valid on rtc_sio no later than SYNC_STAGES+2 CLK after the master's SCLK fall. This is well inside the 25-CLK low phase.
- Simultaneous events: an sclk edge coinciding with synchronized rst fall is ignored (rst wins).
- busy = (state != IDLE).

Optional Feature:
- Macro RTC_WP_EN.
- When defined:
  - reg[7] bit7 is the write-protect bit.
  - While reg[7][7]=1, bus writes to addresses 0-6 are dropped: register unchanged, wr_valid still pulses, wr_addr/wr_data still updated.
  - Writes to address 7 are always accepted.
- When undefined: all addresses are always writable and reg[7] is an ordinary register.

Test Plan:
- Write cmd 8'h84 (addr 2), data 8'h5A → reg[2]=8'h5A; wr_valid one pulse; wr_addr=2; wr_data=8'h5A; host_rdata at host_addr=2 is 8'h5A.
- After that write, read cmd 8'h85 → master captures 8'h5A; sio_oe drops after the 9th fall; rtc_sio returns to Z.
- Invalid cmd 8'h04 followed by 8 data clocks → no register change; no wr_valid; sio never driven; busy drops when rst falls.
- rst deasserted after 4 write-data bits of cmd 8'h86 → reg[3] keeps its old value (8'h00); no wr_valid; the next full transaction works normally.
- Back-to-back reads of all 8 addresses after writing 8'h10+addr to each → each read returns 8'h10+addr.
- RTC_WP_EN defined:
  - Write 8'h80 to addr 7, then 8'hFF to addr 0 → reg[0] unchanged; wr_valid still pulses.
  - Write 8'h00 to addr 7, then 8'hFF to addr 0 → reg[0]=8'hFF.

Source files
------------

// File: rtl/rtc_3wire_responder_if.sv
// Host-side view of the 3-wire responder register file.
// The host reads registers and observes committed bus writes.
interface rtc_3wire_responder_if;
    logic [2:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport master (
        output host_addr,
        input  host_rdata,
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  busy
    );

    modport slave (
        input  host_addr,
        output host_rdata,
        output wr_valid,
        output wr_addr,
        output wr_data,
        output busy
    );
endinterface

// File: rtl/rtc_3wire_responder.sv
// DS1302-style 3-wire slave with an 8 x 8-bit register file.
// Optional write protect via reg[7][7] when RTC_WP_EN is defined.
module rtc_3wire_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  REG_INIT    = 8'h00
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic rtc_rst,
    input  logic rtc_sclk,
    inout  wire  rtc_sio,
    rtc_3wire_responder_if.slave host
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES:0]   rst_sr_q;
    logic [SYNC_STAGES:0]   sclk_sr_q;
    logic [SYNC_STAGES-1:0] sio_sr_q;

    logic [3:0] bit_q, bit_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] sh_q, sh_d;
    logic       oe_q, oe_d;
    logic       out_q, out_d;
    logic       wv_q, wv_d;
    logic [2:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       reg_we;
    logic       wp_ok;

    logic [7:0] regs_q [8];

    logic rst_s, rst_p;
    logic sclk_rise, sclk_fall;
    logic sio_s;
    logic sio_drv;
    logic [7:0] cmd_nx, dat_nx;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rst_sr_q  <= '0;
            sclk_sr_q <= '0;
            sio_sr_q  <= '0;
        end else begin
            rst_sr_q  <= {rst_sr_q[SYNC_STAGES-1:0], rtc_rst};
            sclk_sr_q <= {sclk_sr_q[SYNC_STAGES-1:0], rtc_sclk};
            sio_sr_q  <= {sio_sr_q[SYNC_STAGES-2:0], rtc_sio};
        end
    end

    assign rst_s     = rst_sr_q[SYNC_STAGES-1];
    assign rst_p     = rst_sr_q[SYNC_STAGES];
    assign sclk_rise = sclk_sr_q[SYNC_STAGES-1] & ~sclk_sr_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_sr_q[SYNC_STAGES-1] & sclk_sr_q[SYNC_STAGES];
    assign sio_s     = sio_sr_q[SYNC_STAGES-1];

    assign cmd_nx = {sio_s, cmd_q[7:1]};
    assign dat_nx = {sio_s, sh_q[7:1]};

`ifdef RTC_WP_EN
    assign wp_ok = ~(regs_q[7][7] && (cmd_q[3:1] != 3'd7));
`else
    assign wp_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        out_d   = out_q;
        wv_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        reg_we  = 1'b0;
        // a low chip-enable overrides any coincident sclk edge
        if (!rst_s) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            bit_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rst_p) begin
                        state_d = CMD;
                        bit_d   = 4'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = cmd_nx;
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            bit_d = 4'd0;
                            if (!cmd_nx[7]) begin
                                state_d = HOLD;
                            end else if (cmd_nx[0]) begin
                                state_d = RDATA;
                                sh_d    = regs_q[cmd_nx[3:1]];
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        sh_d  = dat_nx;
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            wv_d    = 1'b1;
                            waddr_d = cmd_q[3:1];
                            wdata_d = dat_nx;
                            reg_we  = wp_ok;
                            state_d = HOLD;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        if (bit_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = HOLD;
                        end else begin
                            oe_d  = 1'b1;
                            out_d = sh_q[0];
                            sh_d  = {1'b0, sh_q[7:1]};
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                HOLD: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            bit_q   <= 4'd0;
            cmd_q   <= 8'h00;
            sh_q    <= 8'h00;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            wv_q    <= 1'b0;
            waddr_q <= 3'd0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            sh_q    <= sh_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            wv_q    <= wv_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= REG_INIT;
            end
        end else if (reg_we) begin
            regs_q[waddr_d] <= wdata_d;
        end
    end

    // release in the same cycle the synchronized enable drops
    assign sio_drv = oe_q & rst_s;
    assign rtc_sio = sio_drv ? out_q : 1'bz;

    assign host.host_rdata = regs_q[host.host_addr];
    assign host.wr_valid   = wv_q;
    assign host.wr_addr    = waddr_q;
    assign host.wr_data    = wdata_q;
    assign host.busy       = (state_q != IDLE);

endmodule
